// File: rtl/mac_share_ctrl.sv
// mac_share_ctrl
// Shares one 8x8 multiply-accumulate unit between two requesters. Only one
// job runs at a time. Grants go round-robin. A job streams len operand pairs
// from the granted requester, sums their products into a 16-bit accumulator
// (which wraps), and then holds the result until the consumer accepts it.
//
// Ports
//   clk, aclr          clock, asynchronous active-high reset
//   req[1:0]           job request per requester (held until granted)
//   len0, len1         operand-pair count per requester, sampled at grant
//   gnt[1:0]           one-hot grant, grant cycle through result acceptance
//   in_valid/in_ready  per-requester operand handshake
//   a0,b0,a1,b1        unsigned 8-bit operands
//   res_valid/res_ready result handshake
//   result, res_id     accumulated sum and owning requester
//   ovf                accumulator wrapped past 16 bits during the job
module mac_share_ctrl #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic [1:0]       gnt,
  input  logic [1:0]       in_valid,
  output logic [1:0]       in_ready,
  input  logic [7:0]       a0,
  input  logic [7:0]       b0,
  input  logic [7:0]       a1,
  input  logic [7:0]       b1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      result,
  output logic             res_id,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic             g_reg;       // index of the granted requester
  logic             ptr_reg;     // round-robin priority pointer
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] count_reg;
  logic [15:0]      acc_reg;
  logic             ovf_reg;

  logic             winner;
  logic [LEN_W-1:0] win_len;
  logic [7:0]       op_a, op_b;
  logic [15:0]      prod;
  logic [16:0]      sum;
  logic [LEN_W-1:0] count_inc;
  logic             fire;
  logic             last;
  logic [1:0]       sel;

  // The pointer requester wins if it is asking. Otherwise the other one wins.
  assign winner    = req[ptr_reg] ? ptr_reg : ~ptr_reg;
  assign win_len   = winner ? len1 : len0;
  assign op_a      = g_reg ? a1 : a0;
  assign op_b      = g_reg ? b1 : b0;
  assign prod      = 16'(op_a) * 16'(op_b);
  assign sum       = {1'b0, acc_reg} + {1'b0, prod};
  assign count_inc = count_reg + 1'b1;
  assign fire      = (state_reg == RUN) && in_valid[g_reg];
  assign last      = (count_inc == len_reg);
  assign sel       = g_reg ? 2'b10 : 2'b01;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    gnt        = 2'b00;
    in_ready   = 2'b00;
    res_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        // A zero-length job skips RUN. It goes straight to DONE with a
        // cleared accumulator.
        if (req != 2'b00) state_next = (win_len == '0) ? DONE : RUN;
      end
      RUN: begin
        gnt      = sel;
        in_ready = sel;
        if (fire && last) state_next = DONE;
      end
      DONE: begin
        gnt       = sel;
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      g_reg     <= 1'b0;
      ptr_reg   <= 1'b0;
      len_reg   <= '0;
      count_reg <= '0;
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req != 2'b00) begin
            g_reg     <= winner;
            len_reg   <= win_len;
            count_reg <= '0;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
          end
        end
        RUN: begin
          if (fire) begin
            acc_reg   <= sum[15:0];
            count_reg <= count_inc;
            ovf_reg   <= ovf_reg | sum[16];  // sticky until the next grant
          end
        end
        DONE: begin
          if (res_ready) ptr_reg <= ~g_reg;
        end
        default: ;
      endcase
    end
  end

  assign result = acc_reg;
  assign res_id = g_reg;
  assign ovf    = ovf_reg;

endmodule

// File: tb/tb_mac_share_ctrl.sv
// Testbench for mac_share_ctrl.
// Directed job table plus hand-written sequences: reset, alternating
// round-robin, and asynchronous reset in the middle of a job.
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge.
module tb_mac_share_ctrl;

  logic        clk = 1'b0;
  logic        aclr = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [3:0]  len0 = '0, len1 = '0;
  logic [1:0]  gnt;
  logic [1:0]  in_valid = 2'b00;
  logic [1:0]  in_ready;
  logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] result;
  logic        res_id;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  mac_share_ctrl #(.LEN_W(4)) dut (
    .clk(clk), .aclr(aclr), .req(req), .len0(len0), .len1(len1), .gnt(gnt),
    .in_valid(in_valid), .in_ready(in_ready), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .res_id(res_id), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       req;
    logic [3:0]       len0;
    logic [3:0]       len1;
    logic [3:0][7:0]  a;
    logic [3:0][7:0]  b;
    logic             id;      // expected winner
    logic [15:0]      res;
    logic             ovf;
    logic             bubble;  // in_valid pattern 1010...
    logic [3:0]       stall;   // DONE cycles with res_ready low
    logic [3:0]       cyc;     // expected req-drive to DONE-exit cycles, 0 = unchecked
  } vec_t;

  function automatic vec_t mk(logic [1:0] rq, int l0, int l1,
                              int xa0, int xb0, int xa1, int xb1,
                              int xa2, int xb2, int xa3, int xb3,
                              logic id, int res, logic ov, logic bub,
                              int stall, int cyc);
    vec_t v;
    v.req = rq; v.len0 = 4'(l0); v.len1 = 4'(l1);
    v.a[0] = 8'(xa0); v.b[0] = 8'(xb0); v.a[1] = 8'(xa1); v.b[1] = 8'(xb1);
    v.a[2] = 8'(xa2); v.b[2] = 8'(xb2); v.a[3] = 8'(xa3); v.b[3] = 8'(xb3);
    v.id = id; v.res = 16'(res); v.ovf = ov; v.bubble = bub;
    v.stall = 4'(stall); v.cyc = 4'(cyc);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v, input int idx);
    int n, k, cyc, stalled;
    logic g, gseen, dseen, phase, rdy_seen, other_bad, stable_bad, finished;
    g = v.id;
    n = g ? int'(v.len1) : int'(v.len0);
    k = 0; cyc = 0; stalled = 0;
    gseen = 0; dseen = 0; phase = 1; rdy_seen = 0;
    other_bad = 0; stable_bad = 0; finished = 0;
    res_ready = (v.stall == 0);
    req = v.req; len0 = v.len0; len1 = v.len1;
    in_valid = 2'b00; in_valid[~g] = 1'b1;  // the non-granted requester must be ignored
    while (cyc < 60 && !finished) begin
      @(negedge clk);
      cyc++;
      if (in_ready[~g]) other_bad = 1;
      if (in_ready[g]) rdy_seen = 1;
      if (!gseen && gnt != 2'b00) begin
        chk($sformatf("job%0d gnt", idx), 32'(gnt), g ? 32'h2 : 32'h1);
        gseen = 1;
        req = 2'b11; len0 = 4'hF; len1 = 4'hF;  // changes that must be ignored
      end
      if (res_valid) begin
        if (!dseen) begin
          dseen = 1;
          chk($sformatf("job%0d result", idx), 32'(result), 32'(v.res));
          chk($sformatf("job%0d res_id", idx), 32'(res_id), 32'(v.id));
          chk($sformatf("job%0d ovf", idx), 32'(ovf), 32'(v.ovf));
          $display("job %0d: res_id=%0d result=%04h ovf=%0d", idx, res_id, result, ovf);
        end else if (result !== v.res || res_id !== v.id || ovf !== v.ovf) begin
          stable_bad = 1;
        end
        if (res_ready) begin
          req = 2'b00;
        end else begin
          stalled++;
          if (stalled >= int'(v.stall)) res_ready = 1'b1;
        end
      end else if (dseen) begin
        chk($sformatf("job%0d exit gnt", idx), 32'(gnt), 32'h0);
        if (v.cyc != 0) chk($sformatf("job%0d cycles", idx), cyc, 32'(v.cyc));
        finished = 1;
      end
      if (!finished) begin
        in_valid[g] = 1'b0;
        if (in_ready[g] && k < n) begin
          if (v.bubble && !phase) begin
            phase = 1;
          end else begin
            phase = 0;
            in_valid[g] = 1'b1;
            if (g) begin a1 = v.a[k]; b1 = v.b[k]; a0 = 8'hFF; b0 = 8'hFF; end
            else   begin a0 = v.a[k]; b0 = v.b[k]; a1 = 8'hFF; b1 = 8'hFF; end
            k++;
          end
        end
      end
    end
    chk($sformatf("job%0d completed", idx), 32'(finished), 32'h1);
    chk($sformatf("job%0d transfers", idx), k, n);
    chk($sformatf("job%0d in_ready seen", idx), 32'(rdy_seen), 32'(n != 0));
    chk($sformatf("job%0d other in_ready", idx), 32'(other_bad), 32'h0);
    if (v.stall != 0) chk($sformatf("job%0d stable", idx), 32'(stable_bad), 32'h0);
    in_valid = 2'b00; req = 2'b00; res_ready = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    int j, last_cyc, cyc;
    vecs[0] = mk(2'b01, 3, 0, 2, 3, 4, 5, 10, 10, 0, 0, 0, 126, 0, 0, 0, 5);
    vecs[1] = mk(2'b10, 0, 2, 255, 255, 255, 255, 0, 0, 0, 0, 1, 16'hFC02, 1, 0, 0, 0);
    vecs[2] = mk(2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3] = mk(2'b01, 4, 0, 3, 7, 11, 13, 200, 100, 1, 2, 0, 20166, 0, 1, 3, 0);
    vecs[4] = mk(2'b11, 5, 1, 9, 9, 0, 0, 0, 0, 0, 0, 1, 81, 0, 0, 0, 3);
    vecs[5] = mk(2'b11, 2, 7, 100, 100, 100, 100, 0, 0, 0, 0, 0, 20000, 0, 0, 0, 0);

    // Reset values while aclr is held, before any clock edge.
    #2;
    chk("rst gnt", 32'(gnt), 32'h0);
    chk("rst in_ready", 32'(in_ready), 32'h0);
    chk("rst res_valid", 32'(res_valid), 32'h0);
    chk("rst result", 32'(result), 32'h0);
    chk("rst res_id/ovf", 32'({res_id, ovf}), 32'h0);
    @(negedge clk);
    aclr = 1'b0;

    // Both requesters keep asking. Grants alternate 0,1,0,1 and each job ends every 3 cycles.
    len0 = 4'd1; len1 = 4'd1; a0 = 8'd1; b0 = 8'd1; a1 = 8'd2; b1 = 8'd2;
    in_valid = 2'b11; res_ready = 1'b1; req = 2'b11;
    j = 0; last_cyc = 0; cyc = 0;
    while (j < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (res_valid) begin
        chk($sformatf("rr%0d res_id", j), 32'(res_id), 32'(j % 2));
        chk($sformatf("rr%0d result", j), 32'(result), (j % 2) ? 32'd4 : 32'd1);
        if (j > 0) chk($sformatf("rr%0d gap", j), cyc - last_cyc, 32'd3);
        $display("rr job %0d: res_id=%0d result=%0d", j, res_id, result);
        last_cyc = cyc;
        j++;
        if (j == 4) begin req = 2'b00; in_valid = 2'b00; end
      end
    end
    chk("rr jobs done", j, 32'd4);
    @(negedge clk);
    chk("rr idle gnt", 32'(gnt), 32'h0);
    res_ready = 1'b0;

    for (int i = 0; i < 6; i++) run_job(vecs[i], i);

    // Asynchronous reset after 2 of 4 transfers.
    @(negedge clk);
    req = 2'b01; len0 = 4'd4;
    @(negedge clk);
    chk("ar gnt", 32'(gnt), 32'h1);
    in_valid = 2'b01; a0 = 8'd50; b0 = 8'd50;
    @(negedge clk);
    @(negedge clk);
    in_valid = 2'b00; req = 2'b00;
    #1 aclr = 1'b1;
    #1;
    chk("ar gnt0", 32'(gnt), 32'h0);
    chk("ar in_ready0", 32'(in_ready), 32'h0);
    chk("ar res_valid0", 32'(res_valid), 32'h0);
    chk("ar result0", 32'(result), 32'h0);
    chk("ar id/ovf0", 32'({res_id, ovf}), 32'h0);
    $display("async reset mid-job applied");
    @(negedge clk);
    aclr = 1'b0;
    run_job(mk(2'b01, 2, 0, 1, 1, 2, 3, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
